// File: rtl/noc_pattern_pkg.sv
// Shared types for the NoC traffic controller: pattern codes, per-PE config
// bus layout and the sequencing FSM encoding.
package noc_pattern_pkg;
  localparam int NUM_PE    = 8;
  localparam int PE_ID_W   = 3;
  localparam int DST_SEQ_W = 24;
  localparam int RATE_W    = 4;
  localparam int MODE_W    = 4;

  localparam logic [MODE_W-1:0] MODE_DST_SEQ = 4'b0001;
  localparam logic [MODE_W-1:0] MODE_TURN    = 4'b0000;

  typedef enum logic [2:0] {
    PAT_COMPLEMENT = 3'd0,
    PAT_BITREV     = 3'd1,
    PAT_ROTATE     = 3'd2,
    PAT_SHUFFLE    = 3'd3,
    PAT_TORNADO    = 3'd4,
    PAT_NEIGHBOR   = 3'd5,
    PAT_HOTSPOT    = 3'd6,
    PAT_TURN       = 3'd7
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_FLUSH, ST_SETTLE, ST_RUN, ST_DONE, ST_ERR
  } state_e;

  // Field layouts match the mesh buses: PE i occupies slice [W*i +: W].
  typedef struct packed {
    logic [NUM_PE-1:0][PE_ID_W-1:0]   send;
    logic [NUM_PE-1:0][PE_ID_W-1:0]   recv;
    logic [NUM_PE-1:0][RATE_W-1:0]    rate;
    logic [NUM_PE-1:0][DST_SEQ_W-1:0] dst;
    logic [NUM_PE-1:0][MODE_W-1:0]    mode;
  } pe_cfg_t;

  function automatic logic [PE_ID_W-1:0] pe_dest(pattern_e p, logic [PE_ID_W-1:0] i);
    case (p)
      PAT_COMPLEMENT: pe_dest = ~i;
      PAT_BITREV:     pe_dest = {i[0], i[1], i[2]};
      PAT_ROTATE:     pe_dest = {i[0], i[2:1]};
      PAT_SHUFFLE:    pe_dest = {i[1:0], i[2]};
      PAT_TORNADO:    pe_dest = i + 3'd3;
      PAT_NEIGHBOR:   pe_dest = i + 3'd1;
      default:        pe_dest = '0;
    endcase
  endfunction
endpackage

// File: rtl/noc_pattern_gen.sv
// Combinational map from a compact traffic pattern selection to the full set
// of per-PE configuration buses.
module noc_pattern_gen
  import noc_pattern_pkg::*;
(
  input  pattern_e             pattern_i,
  input  logic [PE_ID_W-1:0]   pkt_num_i,
  input  logic [RATE_W-1:0]    rate_i,
  output pe_cfg_t              cfg_o
);
  logic [NUM_PE-1:0][PE_ID_W-1:0]   send, recv;
  logic [NUM_PE-1:0][RATE_W-1:0]    rate;
  logic [NUM_PE-1:0][DST_SEQ_W-1:0] dst;
  logic [NUM_PE-1:0][MODE_W-1:0]    mode;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    localparam logic [PE_ID_W-1:0] ID = PE_ID_W'(g);
    // Hotspot: every PE sends one packet to PE0, which expects all seven.
    localparam logic [PE_ID_W-1:0] HS_SEND = (g == 0) ? 3'd0 : 3'd1;
    localparam logic [PE_ID_W-1:0] HS_RECV = (g == 0) ? 3'd7 : 3'd0;

    assign send[g] = (pattern_i == PAT_HOTSPOT) ? HS_SEND :
                     (pattern_i == PAT_TURN)    ? 3'd7    : pkt_num_i;
    assign recv[g] = (pattern_i == PAT_HOTSPOT) ? HS_RECV :
                     (pattern_i == PAT_TURN)    ? 3'd7    : pkt_num_i;
    assign rate[g] = rate_i;
    assign dst[g]  = {{(DST_SEQ_W-PE_ID_W){1'b0}}, pe_dest(pattern_i, ID)};
    assign mode[g] = (pattern_i == PAT_TURN) ? MODE_TURN : MODE_DST_SEQ;
  end

  assign cfg_o = '{send: send, recv: recv, rate: rate, dst: dst, mode: mode};
endmodule

// File: rtl/noc_traffic_ctrl.sv
// Configures the 2x4 mesh from a pattern selection, sequences flush/settle/
// enable, then watches the PE finish flags for completion or timeout.
module noc_traffic_ctrl
  import noc_pattern_pkg::*;
#(
  parameter int          FLUSH_CYC   = 4,
  parameter int          SETTLE_CYC  = 100,
  parameter int          CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               pattern_sel,
  input  logic [2:0]               pkt_num,
  input  logic [3:0]               rate,
  input  logic [NUM_PE-1:0]        pe_task_receive_finish_flag,
  input  logic [NUM_PE-1:0]        pe_task_send_finish_flag,
  output logic [NUM_PE-1:0]        pe_enable,
  output logic [NUM_PE-1:0]        pe_dbg_mode_wire,
  output logic [3*NUM_PE-1:0]      pe_send_num_wire,
  output logic [3*NUM_PE-1:0]      pe_receive_num_wire,
  output logic [4*NUM_PE-1:0]      pe_rate_wire,
  output logic [24*NUM_PE-1:0]     pe_dst_seq_wire,
  output logic [4*NUM_PE-1:0]      pe_mode_wire,
  output logic [NUM_PE-1:0]        pe_flush_wire,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         cycle_count
);
  localparam int PH_W = 16;
  localparam logic [PH_W-1:0]  FLUSH_LAST  = PH_W'(FLUSH_CYC - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO         = CNT_W'(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  pattern_e            sel_q, sel_d;
  logic [2:0]          pkt_q, pkt_d;
  logic [3:0]          rate_q, rate_d;
  pe_cfg_t             cfg_q, cfg_d, gen_cfg;
  logic [NUM_PE-1:0]   en_q, en_d, flush_q, flush_d;
  logic                done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NUM_PE-1:0]   pe_fin;
  logic                all_fin;

  noc_pattern_gen u_gen (
    .pattern_i (sel_q),
    .pkt_num_i (pkt_q),
    .rate_i    (rate_q),
    .cfg_o     (gen_cfg)
  );

  // A PE with nothing to send (or receive) counts as finished on that side.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++)
      pe_fin[i] = (pe_task_send_finish_flag[i]    || cfg_q.send[i] == '0) &&
                  (pe_task_receive_finish_flag[i] || cfg_q.recv[i] == '0);
  end
  assign all_fin = &pe_fin;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    sel_d   = sel_q;
    pkt_d   = pkt_q;
    rate_d  = rate_q;
    cfg_d   = cfg_q;
    en_d    = en_q;
    flush_d = flush_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          sel_d   = pattern_e'(pattern_sel);
          pkt_d   = pkt_num;
          rate_d  = rate;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          flush_d = '1;
          en_d    = '0;
        end
      end
      ST_LOAD: begin
        cfg_d   = gen_cfg;
        ph_d    = '0;
        state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (ph_q == FLUSH_LAST) begin
          flush_d = '0;
          ph_d    = '0;
          state_d = ST_SETTLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          en_d    = '1;
          state_d = ST_RUN;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // cnt_q is still zero in the first RUN cycle, where flags are stale.
        if (cnt_q != '0 && all_fin) begin
          en_d    = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_inc >= TMO) begin
          en_d    = '0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      sel_q   <= PAT_COMPLEMENT;
      pkt_q   <= '0;
      rate_q  <= '0;
      cfg_q   <= '0;
      en_q    <= '0;
      flush_q <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sel_q   <= sel_d;
      pkt_q   <= pkt_d;
      rate_q  <= rate_d;
      cfg_q   <= cfg_d;
      en_q    <= en_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pe_enable           = en_q;
  assign pe_dbg_mode_wire    = '1;
  assign pe_send_num_wire    = cfg_q.send;
  assign pe_receive_num_wire = cfg_q.recv;
  assign pe_rate_wire        = cfg_q.rate;
  assign pe_dst_seq_wire     = cfg_q.dst;
  assign pe_mode_wire        = cfg_q.mode;
  assign pe_flush_wire       = flush_q;
  assign busy                = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign done                = done_q;
  assign timeout_err         = err_q;
  assign cycle_count         = cnt_q;
endmodule

// File: tb/tb_noc_traffic_ctrl.sv
// Randomized bench for noc_traffic_ctrl against a pattern-table reference model.
module tb_noc_traffic_ctrl;
  localparam int F = 4, S = 100, TMO = 50;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]   pattern_sel = '0, pkt_num = '0;
  logic [3:0]   rate = '0;
  logic [7:0]   rflag = '0, sflag = '0;
  logic [7:0]   pe_enable, pe_dbg_mode_wire, pe_flush_wire;
  logic [23:0]  pe_send_num_wire, pe_receive_num_wire;
  logic [31:0]  pe_rate_wire, pe_mode_wire;
  logic [191:0] pe_dst_seq_wire;
  logic         busy, done, timeout_err;
  logic [15:0]  cycle_count;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  noc_traffic_ctrl #(.FLUSH_CYC(F), .SETTLE_CYC(S), .CNT_W(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
    .pkt_num(pkt_num), .rate(rate),
    .pe_task_receive_finish_flag(rflag), .pe_task_send_finish_flag(sflag),
    .pe_enable(pe_enable), .pe_dbg_mode_wire(pe_dbg_mode_wire),
    .pe_send_num_wire(pe_send_num_wire), .pe_receive_num_wire(pe_receive_num_wire),
    .pe_rate_wire(pe_rate_wire), .pe_dst_seq_wire(pe_dst_seq_wire),
    .pe_mode_wire(pe_mode_wire), .pe_flush_wire(pe_flush_wire), .busy(busy),
    .done(done), .timeout_err(timeout_err), .cycle_count(cycle_count)
  );

  task automatic chk(string tag, logic [191:0] act, logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // Reference: destination as plain arithmetic on the PE number.
  function automatic int m_dst(int p, int i);
    case (p)
      0: return 7 - i;
      1: return ((i & 1) << 2) | (i & 2) | (i >> 2);
      2: return (i >> 1) | ((i & 1) << 2);
      3: return ((i << 1) & 7) | (i >> 2);
      4: return (i + 3) % 8;
      5: return (i + 1) % 8;
      default: return 0;
    endcase
  endfunction
  function automatic int m_send(int p, int i, int pk);
    return (p == 6) ? ((i == 0) ? 0 : 1) : (p == 7) ? 7 : pk;
  endfunction
  function automatic int m_recv(int p, int i, int pk);
    return (p == 6) ? ((i == 0) ? 7 : 0) : (p == 7) ? 7 : pk;
  endfunction

  task automatic chk_reset_vals(string tag);
    chk({tag, "_en"}, pe_enable, 8'h00);
    chk({tag, "_flush"}, pe_flush_wire, 8'hFF);
    chk({tag, "_dbg"}, pe_dbg_mode_wire, 8'hFF);
    chk({tag, "_st"}, {busy, done, timeout_err, cycle_count}, '0);
    chk({tag, "_cfg"}, {pe_send_num_wire, pe_receive_num_wire, pe_rate_wire,
                        pe_mode_wire, pe_dst_seq_wire}, '0);
  endtask

  // One traffic run; k = RUN cycle from which the mesh reports all flags.
  task automatic run(int p, int pk, int r, int k, bit st_settle, bit st_run, bit rst_run);
    logic [23:0] e_send, e_recv;
    logic [31:0] e_mode;
    logic [191:0] e_dst;
    logic [7:0] req_s, req_r;
    int e, n, n_end;
    bit allz, e_done;
    e_send = '0; e_recv = '0; e_mode = '0; e_dst = '0; req_s = '0; req_r = '0;
    for (int i = 0; i < 8; i++) begin
      e_send[3*i +: 3] = 3'(m_send(p, i, pk));
      e_recv[3*i +: 3] = 3'(m_recv(p, i, pk));
      e_mode[4*i +: 4] = (p == 7) ? 4'd0 : 4'd1;
      e_dst[24*i +: 24] = 24'(m_dst(p, i));
      req_s[i] = (m_send(p, i, pk) != 0);
      req_r[i] = (m_recv(p, i, pk) != 0);
    end
    allz = (req_s == 0) && (req_r == 0);
    n_end = allz ? 2 : (k < 2 ? 2 : k);
    e_done = (n_end <= TMO);
    if (!e_done) n_end = TMO;

    pattern_sel = 3'(p); pkt_num = 3'(pk); rate = 4'(r); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pattern_sel = 3'($urandom); pkt_num = 3'($urandom); rate = 4'($urandom);
    e = 0;
    while (pe_flush_wire != 8'h00 && e < 400) begin @(posedge clk); #1; e++; end
    chk("flush_lat", e, 1 + F);
    chk("busy_run", busy, 1'b1);
    chk("send_num", pe_send_num_wire, e_send);
    chk("recv_num", pe_receive_num_wire, e_recv);
    chk("rate", pe_rate_wire, {8{4'(r)}});
    chk("mode", pe_mode_wire, e_mode);
    chk("dst", pe_dst_seq_wire, e_dst);
    while (pe_enable != 8'hFF && e < 400) begin
      start = st_settle && (e == 50);
      @(posedge clk); #1; e++;
    end
    start = 1'b0;
    chk("en_lat", e, 1 + F + S);

    n = 0;
    while (n < TMO + 10) begin
      n++;
      sflag = (n >= k) ? (req_s | 8'($urandom)) : 8'h00;
      rflag = (n >= k) ? (req_r | 8'($urandom)) : 8'h00;
      start = st_run && (n == 3);
      @(posedge clk); #1;
      start = 1'b0;
      if (rst_run && n == 5) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_run");
        sflag = '0; rflag = '0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (done || timeout_err) break;
    end
    chk("end_cycle", n, n_end);
    chk("status", {done, timeout_err}, {e_done, !e_done});
    chk("cyc_cnt", cycle_count, 16'(n_end));
    chk("post_en", {pe_enable, pe_flush_wire, busy}, '0);
    sflag = '0; rflag = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold", {cycle_count, done, timeout_err}, {16'(n_end), e_done, !e_done});
    chk("cfg_hold", {pe_send_num_wire, pe_receive_num_wire, pe_mode_wire, pe_dst_seq_wire},
        {e_send, e_recv, e_mode, e_dst});
  endtask

  initial begin
    #12 chk_reset_vals("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 1'b0);
    run(0, 1, 5, 10, 1'b0, 1'b0, 1'b0);
    run(6, 3, 9, 20, 1'b1, 1'b1, 1'b0);
    run(7, 5, 2, 99, 1'b0, 1'b0, 1'b0);
    run(3, 2, 7, TMO, 1'b0, 1'b0, 1'b0);
    run(2, 3, 1, 30, 1'b0, 1'b0, 1'b1);
    run(1, 4, 3, 1, 1'b0, 1'b0, 1'b0);
    run(0, 0, 6, 99, 1'b0, 1'b0, 1'b0);
    for (int p = 1; p <= 5; p++) run(p, int'($urandom_range(1, 7)), int'($urandom_range(0, 15)),
                                     int'($urandom_range(1, 40)), 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++)
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          int'($urandom_range(1, 60)), 1'($urandom), 1'($urandom), 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
